frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter PX_WIDTH, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter PX_HEIGHT, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter N_PRIM, default 5, number of draw engines (4 squares + player), drawn in index order.
REQ-004 SHALL have parameter TIMEOUT, default 65535, maximum cycles allowed per primitive.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port frame_req, input, 1, level: a new scene is ready to be rendered.
REQ-008 SHALL have port vsync, input, 1, one-cycle pulse marking start of display blanking.
REQ-009 SHALL have port prim_start, output, N_PRIM, one-hot one-cycle start pulse to a draw engine.
REQ-010 SHALL have port prim_done, input, N_PRIM, one-cycle completion pulse from each engine.
REQ-011 SHALL have ports prim_wr (1), prim_addr (16) and prim_data (3), all inputs: the OR-combined pixel write request from the engines.
REQ-012 SHALL have ports fb_wr (1), fb_addr (16) and fb_data (3), all outputs: the framebuffer write port.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse on frame completion.
REQ-015 SHALL have port timeout_err, output, 1, sticky primitive-timeout flag.
REQ-016 SHALL have port frame_count, output, 16, number of completed frames.

Function
REQ-017 SHALL implement the states IDLE, WAIT_VS, CLEAR, START_PRIM, WAIT_PRIM and DONE.
REQ-018 IDLE: frame_req=1 SHALL move to WAIT_VS.
REQ-019 WAIT_VS: vsync=1 SHALL move to CLEAR with clr_addr=0; vsync SHALL be ignored in all other states.
REQ-020 CLEAR: each cycle SHALL register fb_wr=1, fb_addr=clr_addr and fb_data=0, then increment clr_addr.
REQ-021 CLEAR: when clr_addr=PX_WIDTH*PX_HEIGHT-1 is issued, SHALL move to START_PRIM with idx=0, so exactly W*H clear writes occur.
REQ-022 START_PRIM: SHALL assert prim_start[idx] for exactly one cycle, clear the timer, and move to WAIT_PRIM.
REQ-023 WAIT_PRIM: fb_wr SHALL equal prim_wr delayed one cycle, qualified by prim_addr<PX_WIDTH*PX_HEIGHT; fb_addr and fb_data SHALL be prim_addr and prim_data delayed one cycle.
REQ-024 Out-of-range addresses SHALL be dropped with fb_wr=0.
REQ-025 WAIT_PRIM: prim_done[idx]=1 SHALL advance to START_PRIM with idx+1, or to DONE when idx=N_PRIM-1.
REQ-026 prim_done bits other than prim_done[idx] SHALL be ignored.
REQ-027 WAIT_PRIM: when the timer reaches TIMEOUT without prim_done[idx], SHALL set timeout_err and advance exactly as if done.
REQ-028 If prim_done[idx] and the timeout occur in the same cycle, SHALL treat it as done and SHALL NOT set timeout_err.
REQ-029 prim_wr outside WAIT_PRIM SHALL be dropped (fb_wr=0 outside CLEAR and WAIT_PRIM).
REQ-030 DONE: SHALL pulse frame_done for one cycle, increment frame_count (wrapping 65535->0), and return to IDLE.
REQ-031 Deasserting frame_req mid-frame SHALL NOT abort the frame.
REQ-032 frame_req held high SHALL start the next frame, which then waits for the next vsync.
REQ-033 All outputs SHALL be registered; fb_* latency is 1 cycle from the source.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state=IDLE, idx=0, clr_addr=0, timer=0, and set fb_wr, fb_addr, fb_data, prim_start, busy, frame_done, timeout_err and frame_count to 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no further fb writes and no frame_done.
REQ-036 After rst_n rises, the first state action SHALL occur on the following clock edge.

Structure
REQ-037 PX_WIDTH, PX_HEIGHT, the framebuffer size, the state encodings and the 3-bit colour type SHALL live in the shared consts package.
REQ-038 The clear address generator SHALL be one sub-module, fb_clear_gen (start in, addr/wr/last out).

Verification
REQ-039 W=4, H=2, N_PRIM=2, frame_req=1, vsync pulse -> 8 writes, addr 0..7, data 0, consecutive cycles; then prim_start=2'b01.
REQ-040 Engine 0 writes addr 3 data 5, then done; engine 1 done -> fb write (3,5) one cycle later, prim_start 2'b10, frame_done pulse, frame_count=1.
REQ-041 prim_addr=8 with prim_wr=1 (W*H=8) -> fb_wr stays 0.
REQ-042 TIMEOUT=8, engine 0 never done -> timeout_err=1 after 8 cycles in WAIT_PRIM, prim_start=2'b10 follows, frame still completes.
REQ-043 Spurious prim_done[1] during engine 0, and vsync during CLEAR -> no state change, clear count still 8.
REQ-044 rst_n low during CLEAR at addr 4 -> all outputs 0 immediately, busy=0, no frame_done; a new frame_req+vsync restarts the clear at 0.

Source files
------------

// File: rtl/frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// frame_scheduler_pkg
// Shared constants and types for the frame scheduler:
//   - default framebuffer geometry and the derived framebuffer size
//   - framebuffer address width and the 3-bit colour type
//   - scheduler state encodings
// -----------------------------------------------------------------------------
package frame_scheduler_pkg;

  localparam int unsigned DEF_PX_WIDTH  = 160;
  localparam int unsigned DEF_PX_HEIGHT = 120;
  localparam int unsigned DEF_FB_SIZE   = DEF_PX_WIDTH * DEF_PX_HEIGHT;
  localparam int unsigned FB_ADDR_W     = 16;

  typedef logic [2:0] colour_t;
  localparam colour_t COLOUR_BLACK = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_VS    = 3'd1,
    ST_CLEAR      = 3'd2,
    ST_START_PRIM = 3'd3,
    ST_WAIT_PRIM  = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Number of pixels in a width x height framebuffer.
  function automatic int unsigned fb_size(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/frame_scheduler_fb_clear_gen.sv
// -----------------------------------------------------------------------------
// fb_clear_gen
// Sweeps the framebuffer address range once per start pulse.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : one-cycle pulse, begins a sweep at address 0
//   addr   : current clear address
//   wr     : high while a sweep is in progress (addr is valid)
//   last   : high while addr is the final framebuffer address
// -----------------------------------------------------------------------------
module fb_clear_gen
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned FB_SIZE = DEF_FB_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [FB_ADDR_W-1:0] addr,
  output logic                 wr,
  output logic                 last
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_SIZE - 1);

  logic [FB_ADDR_W-1:0] r_addr;
  logic                 r_active;
  logic                 w_at_last;

  assign w_at_last = (r_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_addr   <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_at_last) begin
        // Park at 0 so the next sweep needs no extra setup.
        r_addr   <= '0;
        r_active <= 1'b0;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign addr = r_addr;
  assign wr   = r_active;
  assign last = r_active && w_at_last;

endmodule

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
// Sequences one rendered frame: wait for frame_req, wait for vsync, clear the
// framebuffer to black, then start each draw engine in index order and forward
// its pixel writes to the framebuffer until it reports done (or times out).
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   frame_req    : level, a new scene is ready
//   vsync        : one-cycle pulse, start of blanking (used only in WAIT_VS)
//   prim_start   : one-hot one-cycle start pulse to draw engine idx
//   prim_done    : per-engine one-cycle completion pulse
//   prim_wr/addr/data : OR-combined engine pixel write request
//   fb_wr/addr/data   : registered framebuffer write port (1 cycle latency)
//   busy         : high in every state except IDLE
//   frame_done   : one-cycle pulse at frame completion
//   timeout_err  : sticky, an engine exceeded TIMEOUT cycles
//   frame_count  : completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned PX_WIDTH  = DEF_PX_WIDTH,
  parameter int unsigned PX_HEIGHT = DEF_PX_HEIGHT,
  parameter int unsigned N_PRIM    = 5,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_req,
  input  logic                 vsync,
  output logic [N_PRIM-1:0]    prim_start,
  input  logic [N_PRIM-1:0]    prim_done,
  input  logic                 prim_wr,
  input  logic [FB_ADDR_W-1:0] prim_addr,
  input  colour_t              prim_data,
  output logic                 fb_wr,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output colour_t              fb_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic [15:0]          frame_count
);

  localparam int unsigned FB_SIZE  = fb_size(PX_WIDTH, PX_HEIGHT);
  // One extra bit so a full 64K-pixel framebuffer still compares correctly.
  localparam logic [FB_ADDR_W:0] FB_LIMIT = (FB_ADDR_W + 1)'(FB_SIZE);
  localparam int unsigned IDX_W    = (N_PRIM > 1) ? $clog2(N_PRIM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PRIM - 1);
  localparam int unsigned TMR_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The timer counts completed WAIT_PRIM cycles; the TIMEOUT-th cycle is the
  // one in which it holds TIMEOUT-1.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic [TMR_W-1:0]     r_timer;

  logic                 r_fb_wr;
  logic [FB_ADDR_W-1:0] r_fb_addr;
  colour_t              r_fb_data;
  logic [N_PRIM-1:0]    r_prim_start;
  logic                 r_busy;
  logic                 r_frame_done;
  logic                 r_timeout_err;
  logic [15:0]          r_frame_count;

  logic                 w_fb_wr_next;
  logic [FB_ADDR_W-1:0] w_fb_addr_next;
  colour_t              w_fb_data_next;
  logic [N_PRIM-1:0]    w_prim_start_next;
  logic                 w_busy_next;
  logic                 w_frame_done_next;
  logic                 w_timeout_err_next;
  logic [15:0]          w_frame_count_next;

  logic                 w_clr_start;
  logic [FB_ADDR_W-1:0] w_clr_addr;
  logic                 w_clr_wr;
  logic                 w_clr_last;

  logic [N_PRIM-1:0]    w_idx_onehot;
  logic                 w_done_sel;
  logic                 w_timer_hit;
  logic                 w_prim_adv;
  logic                 w_addr_ok;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_PRIM; gi++) begin : g_onehot
    assign w_idx_onehot[gi] = (r_idx == IDX_W'(gi));
  end

  // Only the engine currently being waited on can complete the primitive.
  assign w_done_sel  = prim_done[r_idx];
  assign w_timer_hit = (r_timer == TMR_LAST);
  assign w_prim_adv  = (r_state == ST_WAIT_PRIM) && (w_done_sel || w_timer_hit);
  assign w_addr_ok   = ({1'b0, prim_addr} < FB_LIMIT);
  assign w_clr_start = (r_state == ST_WAIT_VS) && vsync;

  fb_clear_gen #(
    .FB_SIZE (FB_SIZE)
  ) u_clear_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_clr_start),
    .addr  (w_clr_addr),
    .wr    (w_clr_wr),
    .last  (w_clr_last)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:       if (frame_req) w_state_next = ST_WAIT_VS;
      ST_WAIT_VS:    if (vsync) w_state_next = ST_CLEAR;
      ST_CLEAR:      if (w_clr_last) w_state_next = ST_START_PRIM;
      ST_START_PRIM: w_state_next = ST_WAIT_PRIM;
      ST_WAIT_PRIM: begin
        if (w_prim_adv) begin
          w_state_next = (r_idx == IDX_LAST) ? ST_DONE : ST_START_PRIM;
        end
      end
      ST_DONE:       w_state_next = ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fb_wr_next       = 1'b0;
    w_fb_addr_next     = r_fb_addr;
    w_fb_data_next     = r_fb_data;
    w_prim_start_next  = '0;
    // busy follows the state the FSM is entering so it lines up with it.
    w_busy_next        = (w_state_next != ST_IDLE);
    w_frame_done_next  = 1'b0;
    w_timeout_err_next = r_timeout_err;
    w_frame_count_next = r_frame_count;
    unique case (r_state)
      ST_CLEAR: begin
        w_fb_wr_next   = w_clr_wr;
        w_fb_addr_next = w_clr_addr;
        w_fb_data_next = COLOUR_BLACK;
      end
      ST_START_PRIM: begin
        w_prim_start_next = w_idx_onehot;
      end
      ST_WAIT_PRIM: begin
        w_fb_wr_next   = prim_wr && w_addr_ok;
        w_fb_addr_next = prim_addr;
        w_fb_data_next = prim_data;
        // A done arriving on the deadline cycle wins over the timeout.
        if (w_timer_hit && !w_done_sel) begin
          w_timeout_err_next = 1'b1;
        end
      end
      ST_DONE: begin
        w_frame_done_next  = 1'b1;
        w_frame_count_next = r_frame_count + 16'd1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_wr       <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_data     <= COLOUR_BLACK;
      r_prim_start  <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_fb_wr       <= w_fb_wr_next;
      r_fb_addr     <= w_fb_addr_next;
      r_fb_data     <= w_fb_data_next;
      r_prim_start  <= w_prim_start_next;
      r_busy        <= w_busy_next;
      r_frame_done  <= w_frame_done_next;
      r_timeout_err <= w_timeout_err_next;
      r_frame_count <= w_frame_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Primitive index and per-primitive timer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_timer <= '0;
    end else begin
      if (r_state == ST_CLEAR && w_clr_last) begin
        r_idx <= '0;
      end else if (w_prim_adv && r_idx != IDX_LAST) begin
        r_idx <= r_idx + 1'b1;
      end

      if (r_state == ST_START_PRIM) begin
        r_timer <= '0;
      end else if (r_state == ST_WAIT_PRIM && !w_timer_hit) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign fb_wr       = r_fb_wr;
  assign fb_addr     = r_fb_addr;
  assign fb_data     = r_fb_data;
  assign prim_start  = r_prim_start;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
// Directed frame sequence with randomised engine traffic for a 4x2
// framebuffer, two engines and an 8-cycle primitive timeout. Expected values
// come from a frame-level model: a clear writes every pixel black once, each
// engine's in-range writes reach the framebuffer one cycle later, an engine
// that stays silent for TIMEOUT cycles raises the sticky error.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NP = 2;
  localparam int TO = 8;
  localparam int FB = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_req;
  logic          vsync;
  logic [NP-1:0] prim_start;
  logic [NP-1:0] prim_done;
  logic          prim_wr;
  logic [15:0]   prim_addr;
  logic [2:0]    prim_data;
  logic          fb_wr;
  logic [15:0]   fb_addr;
  logic [2:0]    fb_data;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;
  logic [15:0]   frame_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        exp_to;
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  frame_scheduler #(
    .PX_WIDTH  (W),
    .PX_HEIGHT (H),
    .N_PRIM    (NP),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_req   (frame_req),
    .vsync       (vsync),
    .prim_start  (prim_start),
    .prim_done   (prim_done),
    .prim_wr     (prim_wr),
    .prim_addr   (prim_addr),
    .prim_data   (prim_data),
    .fb_wr       (fb_wr),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fb_wr"}, 32'(fb_wr), 0);
    chk({tag, "_fb_addr"}, 32'(fb_addr), 0);
    chk({tag, "_fb_data"}, 32'(fb_data), 0);
    chk({tag, "_prim_start"}, 32'(prim_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_frame_count"}, 32'(frame_count), 0);
  endtask

  // vsync pulse, then W*H consecutive black writes, then prim_start for engine 0.
  // With glitch set, vsync, prim_done and prim_wr are poked during the clear.
  task automatic run_clear(input bit glitch);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("vs_fb_wr", 32'(fb_wr), 0);
    chk("vs_busy", 32'(busy), 1);
    for (int k = 0; k < FB; k++) begin
      vsync     = glitch && (k == 2);
      prim_done = glitch ? '1 : '0;
      prim_wr   = glitch;
      prim_addr = 16'd1;
      prim_data = 3'd7;
      tick();
      chk("clr_fb_wr", 32'(fb_wr), 1);
      chk("clr_fb_addr", 32'(fb_addr), 32'(k));
      chk("clr_fb_data", 32'(fb_data), 0);
      chk("clr_prim_start", 32'(prim_start), 0);
    end
    vsync     = 1'b0;
    prim_done = '0;
    prim_wr   = 1'b0;
    tick();
    chk("clr_end_fb_wr", 32'(fb_wr), 0);
    chk("first_prim_start", 32'(prim_start), 1);
    $display("clear: %0d writes, glitch=%0d", FB, glitch);
  endtask

  // Engine idx has just been started. It issues n write cycles and signals
  // done with the last one, or never signals done.
  task automatic run_engine(input int idx, input int n, input bit never_done,
                            input bit spurious, input bit directed);
    int            cycles;
    logic          dw;
    logic [15:0]   da;
    logic [2:0]    dd;
    logic          exp_wr;
    logic [NP-1:0] onehot;
    logic [NP-1:0] other;
    cycles = never_done ? TO : n;
    onehot = NP'(1) << idx;
    other  = ~onehot;
    for (int c = 1; c <= cycles; c++) begin
      dw = ($urandom_range(0, 3) != 0);
      da = 16'($urandom_range(0, FB + 3));
      dd = 3'($urandom_range(0, 7));
      if (directed && c == 1) begin
        dw = 1'b1; da = 16'(FB); dd = 3'd6;
      end
      if (directed && c == cycles) begin
        dw = 1'b1; da = 16'd3; dd = 3'd5;
      end
      prim_wr   = dw;
      prim_addr = da;
      prim_data = dd;
      if (!never_done && c == cycles) prim_done = onehot;
      else if (spurious)              prim_done = other;
      else                            prim_done = '0;
      tick();
      if (never_done && c == TO) exp_to = 1'b1;
      exp_wr = dw && (int'(da) < FB);
      chk("eng_fb_wr", 32'(fb_wr), 32'(exp_wr));
      if (exp_wr) begin
        chk("eng_fb_addr", 32'(fb_addr), 32'(da));
        chk("eng_fb_data", 32'(fb_data), 32'(dd));
      end
      chk("eng_prim_start_quiet", 32'(prim_start), 0);
      chk("eng_timeout_err", 32'(timeout_err), 32'(exp_to));
      chk("eng_busy", 32'(busy), 1);
    end
    // A write while the engine is no longer active must not reach the framebuffer.
    prim_wr   = 1'b1;
    prim_addr = 16'd1;
    prim_data = 3'd7;
    prim_done = '0;
    tick();
    prim_wr = 1'b0;
    chk("post_fb_wr_dropped", 32'(fb_wr), 0);
    if (idx < NP - 1) begin
      chk("next_prim_start", 32'(prim_start), 32'(onehot << 1));
      chk("mid_frame_done", 32'(frame_done), 0);
    end else begin
      exp_count = exp_count + 16'd1;
      chk("frame_done_pulse", 32'(frame_done), 1);
      chk("frame_count", 32'(frame_count), 32'(exp_count));
      chk("end_busy", 32'(busy), 0);
      chk("end_prim_start", 32'(prim_start), 0);
    end
    $display("engine %0d: cycles=%0d never_done=%0d timeout_err=%0d",
             idx, cycles, never_done, timeout_err);
  endtask

  task automatic run_frame(input bit drop_req, input int pre_vs, input bit glitch,
                           input int n0, input bit nd0, input int n1, input bit directed);
    frame_req = 1'b1;
    tick();
    chk("start_busy", 32'(busy), 1);
    chk("start_frame_done_clear", 32'(frame_done), 0);
    chk("start_fb_wr", 32'(fb_wr), 0);
    if (drop_req) frame_req = 1'b0;
    for (int i = 0; i < pre_vs; i++) begin
      tick();
      chk("wait_vs_busy", 32'(busy), 1);
      chk("wait_vs_fb_wr", 32'(fb_wr), 0);
    end
    run_clear(glitch);
    run_engine(0, n0, nd0, glitch, directed);
    run_engine(1, n1, 1'b0, 1'b0, 1'b0);
    $display("frame complete: frame_count=%0d", frame_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    frame_req = 1'b0;
    vsync     = 1'b0;
    prim_done = '0;
    prim_wr   = 1'b0;
    prim_addr = '0;
    prim_data = '0;
    exp_to    = 1'b0;
    exp_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // vsync while idle is ignored.
    rst_n = 1'b1;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("idle_vsync_busy", 32'(busy), 0);

    // Directed frame: out-of-range write, then (3,5); frame_req dropped mid-frame.
    run_frame(1'b1, 2, 1'b0, 2, 1'b0, 3, 1'b1);
    // Glitches during clear, spurious done from engine 1, engine 0 done exactly
    // on the deadline cycle; frame_req stays high into the next frame.
    run_frame(1'b0, 0, 1'b1, TO, 1'b0, 1, 1'b0);
    // Engine 0 never completes.
    run_frame(1'b0, 1, 1'b0, 1, 1'b1, 4, 1'b0);
    for (int f = 0; f < 3; f++) begin
      run_frame(f[0], $urandom_range(0, 3), 1'b0,
                $urandom_range(1, TO - 1), 1'b0, $urandom_range(1, TO - 1), 1'b0);
    end

    // Reset in the middle of a clear.
    frame_req = 1'b1;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      tick();
      chk("pre_rst_clr_addr", 32'(fb_addr), 32'(k));
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_to    = 1'b0;
    exp_count = '0;
    for (int i = 0; i < 3; i++) begin
      vsync = i[0];
      tick();
      chk("in_rst_fb_wr", 32'(fb_wr), 0);
      chk("in_rst_frame_done", 32'(frame_done), 0);
      chk("in_rst_busy", 32'(busy), 0);
    end
    vsync = 1'b0;
    // First state action only on the edge after release.
    rst_n = 1'b1;
    #1;
    chk("release_busy", 32'(busy), 0);
    tick();
    chk("release_busy_edge", 32'(busy), 1);
    run_clear(1'b0);
    run_engine(0, $urandom_range(1, TO), 1'b0, 1'b0, 1'b0);
    run_engine(1, $urandom_range(1, TO), 1'b0, 1'b0, 1'b0);

    frame_req = 1'b0;
    tick();
    chk("final_frame_done_clear", 32'(frame_done), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
